// File: rtl/riscv_pkg.sv
// Shared definitions for the single-issue RISC-V core.
// Fetch FSM encoding and opcode constants used by fetch and decode.
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INSTR_BYTES      = 4;

    typedef enum logic {
        RESET_HOLD,
        RUN
    } fetch_state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO with synchronous flush and occupancy count.
// Used for both buffered instructions and in-flight fetch addresses.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // A full FIFO may only be written when the head leaves in the same cycle
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n) !(do_push && full && !do_pop)
    );

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem reads, buffers
// returned words for decode and squashes stale fetches on redirect.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int                    MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  PCSrc,
    input  logic [DATA_WIDTH-1:0] pc_target,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc
);

    localparam int             DW    = DATA_WIDTH;
    localparam int             CW    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [DW-1:0]  STEP  = DW'(INSTR_BYTES);
    localparam logic [CW:0]    SLOTS = (CW + 1)'(MAX_OUTSTANDING);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [DW-1:0]   pc;
    logic [DW-1:0]   pc_nxt;
    logic [DW-1:0]   tgt;
    logic [DW-1:0]   rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   out_nxt;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   drop_nxt;
    logic [CW-1:0]   icount;
    logic [CW:0]     occupancy;
    logic [2*DW-1:0] head;
    logic            req_hs;
    logic            ipop;
    logic            ipush;

    assign tgt    = pc_target & ~(STEP - 1'b1);
    assign req_hs = imem_req_valid && imem_req_ready;
    assign ipop   = instr_valid && instr_ready;
    assign ipush  = imem_rsp_valid && (drop_cnt == '0) && !PCSrc;

    // A slot freed by this cycle's pop is free before any new response lands
    assign occupancy = {1'b0, outstanding} + {1'b0, icount}
                     - {{CW{1'b0}}, ipop};

    assign imem_req_valid = (state == RUN) && (occupancy < SLOTS);
    assign imem_addr      = pc;

    assign instr_valid = (icount != '0);
    assign instr       = instr_valid ? head[2*DW-1:DW] : '0;
    assign instr_pc    = instr_valid ? head[DW-1:0]    : '0;

    always_comb begin
        state_nxt = state;
        unique case (state)
            RESET_HOLD: state_nxt = RUN;
            RUN:        state_nxt = RUN;
            default:    state_nxt = RESET_HOLD;
        endcase
    end

    always_comb begin
        out_nxt = outstanding;
        if (req_hs && !imem_rsp_valid) begin
            out_nxt = outstanding + 1'b1;
        end else if (!req_hs && imem_rsp_valid) begin
            out_nxt = outstanding - 1'b1;
        end
    end

    always_comb begin
        drop_nxt = drop_cnt;
        pc_nxt   = pc;
        if (PCSrc) begin
            drop_nxt = out_nxt;
            pc_nxt   = tgt;
        end else begin
            if (imem_rsp_valid && drop_cnt != '0) drop_nxt = drop_cnt - 1'b1;
            if (req_hs) pc_nxt = pc + STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RESET_HOLD;
            pc       <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            drop_cnt <= drop_nxt;
        end
    end

    // Addresses of in-flight requests; its count is the outstanding total
    fetch_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (DW)
    ) u_pc_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (1'b0),
        .push  (req_hs),
        .wdata (pc),
        .pop   (imem_rsp_valid),
        .rdata (rsp_pc),
        .count (outstanding)
    );

    fetch_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (2 * DW)
    ) u_instr_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (PCSrc),
        .push  (ipush),
        .wdata ({imem_rsp_data, rsp_pc}),
        .pop   (ipop),
        .rdata (head),
        .count (icount)
    );

    a_rsp_expected: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && outstanding == '0)
    );

endmodule
